// File: rtl/lsq_mem_ctrl_pkg.sv
// Shared types and sizing for the LSQ memory-port controller.
package lsq_pkg;

    localparam int LSQSZ   = 16;
    localparam int NTAG    = 16;
    localparam int MAX_OUT = 8;
    localparam int LQ_W    = $clog2(LSQSZ);
    localparam int TAG_W   = $clog2(NTAG);
    localparam int CNT_W   = TAG_W + 1;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } BUS_COMMAND;

    typedef struct packed {
        logic            valid;
        logic            squashed;
        logic [LQ_W-1:0] lq_idx;
    } mem_tag_entry;

endpackage

// File: rtl/lsq_mem_ctrl_if.sv
// LSQ-side requests, memory bus and return path bundled for the controller.
interface lsq_mem_ctrl_if;
    import lsq_pkg::*;

    logic                        except;
    logic [LSQSZ-1:0]            ld_miss;
    logic [LSQSZ-1:0][15:0]      ld_miss_addr;
    logic                        st_wr_en;
    logic [15:0]                 st_wr_addr;
    logic [31:0]                 st_wr_data;
    MEM_SIZE                     st_wr_size;
    logic                        st_wr_ready;
    logic [TAG_W-1:0]            mem2proc_response;
    logic [31:0]                 mem2proc_data;
    logic [TAG_W-1:0]            mem2proc_tag;
    BUS_COMMAND                  proc2mem_command;
    logic [15:0]                 proc2mem_addr;
    logic [31:0]                 proc2mem_data;
    MEM_SIZE                     proc2mem_size;
    logic [LSQSZ-1:0]            ld_gnt;
    logic [LSQSZ-1:0]            mem_feedback;
    logic [31:0]                 mem_data;
    logic [TAG_W-1:0]            num_outstanding;

    modport master (
        output except, ld_miss, ld_miss_addr, st_wr_en, st_wr_addr, st_wr_data, st_wr_size,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  st_wr_ready, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
               ld_gnt, mem_feedback, mem_data, num_outstanding
    );

    modport slave (
        input  except, ld_miss, ld_miss_addr, st_wr_en, st_wr_addr, st_wr_data, st_wr_size,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output st_wr_ready, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
               ld_gnt, mem_feedback, mem_data, num_outstanding
    );

endinterface

// File: rtl/lsq_mem_ctrl_rr_arbiter.sv
// One-hot round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic          found;
    logic [IW-1:0] j;

    // N is a power of two, so the IW-bit add wraps LSQSZ-1 back to 0.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = ptr_i + IW'(i);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/lsq_mem_ctrl.sv
// Arbitrates the memory port between store write-throughs and LQ load misses,
// tracks load tags and routes returning data to the owning LQ entry.
module lsq_mem_ctrl
    import lsq_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    lsq_mem_ctrl_if.slave bus
);
    mem_tag_entry     tbl_q [NTAG];
    logic [LQ_W-1:0]  rr_ptr_q;
    logic [LSQSZ-1:0] fb_q;
    logic [31:0]      mem_data_q;

    logic [LSQSZ-1:0] arb_gnt;
    logic [LQ_W-1:0]  arb_idx;
    logic [CNT_W-1:0] vld_cnt, live_cnt;
    logic             accepted, ld_ok, ld_acc, ret_hit;
    mem_tag_entry     ret_ent;

    rr_arbiter #(.N(LSQSZ)) u_arb (
        .req_i (bus.ld_miss),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Squashed tags still occupy memory slots, so they gate new loads.
    always_comb begin
        vld_cnt  = '0;
        live_cnt = '0;
        for (int t = 1; t < NTAG; t++) begin
            vld_cnt  = vld_cnt  + CNT_W'(tbl_q[t].valid);
            live_cnt = live_cnt + CNT_W'(tbl_q[t].valid & ~tbl_q[t].squashed);
        end
    end

    assign accepted            = |bus.mem2proc_response;
    assign ld_ok               = |bus.ld_miss && (vld_cnt < CNT_W'(MAX_OUT)) && !bus.except;
    assign ret_ent             = tbl_q[bus.mem2proc_tag];
    assign ret_hit             = |bus.mem2proc_tag && ret_ent.valid;
    assign bus.num_outstanding = live_cnt[TAG_W-1:0];
    assign bus.mem_feedback    = bus.except ? '0 : fb_q;
    assign bus.mem_data        = mem_data_q;

    always_comb begin
        bus.proc2mem_command = NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = BYTE;
        bus.st_wr_ready      = 1'b0;
        bus.ld_gnt           = '0;
        ld_acc               = 1'b0;
        if (bus.st_wr_en) begin
            bus.proc2mem_command = STORE;
            bus.proc2mem_addr    = bus.st_wr_addr;
            bus.proc2mem_data    = bus.st_wr_data;
            bus.proc2mem_size    = bus.st_wr_size;
            bus.st_wr_ready      = accepted;
        end else if (ld_ok) begin
            bus.proc2mem_command = LOAD;
            bus.proc2mem_addr    = {bus.ld_miss_addr[arb_idx][15:2], 2'b00};
            bus.proc2mem_size    = WORD;
            ld_acc               = accepted;
            bus.ld_gnt           = accepted ? arb_gnt : '0;
        end
    end

    // Order matters: squash, then free, then allocate so a same-tag alloc wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NTAG; t++) tbl_q[t] <= '0;
            rr_ptr_q   <= '0;
            fb_q       <= '0;
            mem_data_q <= '0;
        end else begin
            fb_q <= '0;
            for (int t = 0; t < NTAG; t++)
                if (bus.except && tbl_q[t].valid) tbl_q[t].squashed <= 1'b1;
            if (ret_hit) begin
                tbl_q[bus.mem2proc_tag].valid <= 1'b0;
                if (!ret_ent.squashed && !bus.except) begin
                    fb_q[ret_ent.lq_idx] <= 1'b1;
                    mem_data_q           <= bus.mem2proc_data;
                end
            end
            if (ld_acc) begin
                tbl_q[bus.mem2proc_response] <= '{valid: 1'b1, squashed: 1'b0, lq_idx: arb_idx};
                rr_ptr_q                     <= arb_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// Directed bench for lsq_mem_ctrl: priority, round-robin, routing, flush, full, backpressure.
module tb_lsq_mem_ctrl;
    import lsq_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    lsq_mem_ctrl_if bus ();

    lsq_mem_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic idle();
        bus.except            = 1'b0;
        bus.ld_miss           = '0;
        bus.ld_miss_addr      = '0;
        bus.st_wr_en          = 1'b0;
        bus.st_wr_addr        = '0;
        bus.st_wr_data        = '0;
        bus.st_wr_size        = BYTE;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    // Inputs change just after the edge; outputs are sampled mid-cycle.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc(); cyc(); settle();
        chk("rst_cmd",  32'(bus.proc2mem_command), 32'd0);
        chk("rst_addr", 32'(bus.proc2mem_addr), 32'd0);
        chk("rst_data", bus.proc2mem_data, 32'd0);
        chk("rst_size", 32'(bus.proc2mem_size), 32'd0);
        chk("rst_gnt",  32'(bus.ld_gnt), 32'd0);
        chk("rst_rdy",  32'(bus.st_wr_ready), 32'd0);
        chk("rst_fb",   32'(bus.mem_feedback), 32'd0);
        chk("rst_mdat", bus.mem_data, 32'd0);
        chk("rst_nout", 32'(bus.num_outstanding), 32'd0);

        // store beats a pending load
        cyc(); reset = 1'b0;
        bus.st_wr_en = 1'b1; bus.st_wr_addr = 16'h0104; bus.st_wr_data = 32'hCAFEF00D;
        bus.st_wr_size = HALF; bus.ld_miss = 16'h0008; bus.ld_miss_addr[3] = 16'h0307;
        bus.mem2proc_response = 4'd5; settle();
        chk("st_cmd",  32'(bus.proc2mem_command), 32'd2);
        chk("st_addr", 32'(bus.proc2mem_addr), 32'h0104);
        chk("st_data", bus.proc2mem_data, 32'hCAFEF00D);
        chk("st_size", 32'(bus.proc2mem_size), 32'd1);
        chk("st_rdy",  32'(bus.st_wr_ready), 32'd1);
        chk("st_gnt",  32'(bus.ld_gnt), 32'd0);
        cyc(); bus.st_wr_en = 1'b0; bus.mem2proc_response = 4'd6; settle();
        chk("ld3_cmd",  32'(bus.proc2mem_command), 32'd1);
        chk("ld3_addr", 32'(bus.proc2mem_addr), 32'h0304);
        chk("ld3_size", 32'(bus.proc2mem_size), 32'd2);
        chk("ld3_gnt",  32'(bus.ld_gnt), 32'h0008);
        chk("ld3_rdy",  32'(bus.st_wr_ready), 32'd0);

        // return routing; rr_ptr now 4
        cyc(); bus.ld_miss = 16'h0080; bus.ld_miss_addr[7] = 16'h0702; bus.mem2proc_response = 4'd9; settle();
        chk("ld7_gnt",  32'(bus.ld_gnt), 32'h0080);
        chk("ld7_addr", 32'(bus.proc2mem_addr), 32'h0700);
        chk("nout1",    32'(bus.num_outstanding), 32'd1);
        cyc(); bus.ld_miss = '0; bus.mem2proc_response = '0;
        bus.mem2proc_tag = 4'd9; bus.mem2proc_data = 32'hDEADBEEF; settle();
        chk("nout2", 32'(bus.num_outstanding), 32'd2);
        chk("fb_pre", 32'(bus.mem_feedback), 32'd0);
        cyc(); bus.mem2proc_tag = 4'd6; bus.mem2proc_data = 32'h11111111; settle();
        chk("fb7",   32'(bus.mem_feedback), 32'h0080);
        chk("dat7",  bus.mem_data, 32'hDEADBEEF);
        chk("nout3", 32'(bus.num_outstanding), 32'd1);
        cyc(); bus.mem2proc_tag = 4'd12; bus.mem2proc_data = 32'hBAD0BAD0; settle();
        chk("fb3",   32'(bus.mem_feedback), 32'h0008);
        chk("dat3",  bus.mem_data, 32'h11111111);
        chk("nout4", 32'(bus.num_outstanding), 32'd0);
        cyc(); bus.mem2proc_tag = '0; bus.mem2proc_data = '0; settle();
        chk("fb_badtag", 32'(bus.mem_feedback), 32'd0);

        // round robin from rr_ptr=8
        cyc(); bus.ld_miss = 16'h0011; bus.ld_miss_addr[0] = 16'h0010; bus.ld_miss_addr[4] = 16'h0040;
        bus.mem2proc_response = 4'd1; settle();
        chk("rr_a", 32'(bus.ld_gnt), 32'h0001);
        cyc(); bus.mem2proc_response = 4'd2; settle();
        chk("rr_b", 32'(bus.ld_gnt), 32'h0010);
        cyc(); bus.mem2proc_response = 4'd3; settle();
        chk("rr_c", 32'(bus.ld_gnt), 32'h0001);
        cyc(); bus.ld_miss = 16'h4000; bus.ld_miss_addr[14] = 16'h0E00; bus.mem2proc_response = 4'd4; settle();
        chk("rr_14", 32'(bus.ld_gnt), 32'h4000);
        cyc(); bus.ld_miss = 16'h8001; bus.ld_miss_addr[15] = 16'h0F00; bus.mem2proc_response = 4'd5; settle();
        chk("rr_15",   32'(bus.ld_gnt), 32'h8000);
        chk("rr_15_a", 32'(bus.proc2mem_addr), 32'h0F00);
        cyc(); bus.mem2proc_response = 4'd6; settle();
        chk("rr_wrap",   32'(bus.ld_gnt), 32'h0001);
        chk("rr_wrap_a", 32'(bus.proc2mem_addr), 32'h0010);

        // fill to MAX_OUT; rr_ptr=1
        cyc(); bus.ld_miss = 16'h0003; bus.ld_miss_addr[1] = 16'h0100; bus.mem2proc_response = 4'd7; settle();
        chk("fill_1", 32'(bus.ld_gnt), 32'h0002);
        chk("nout6",  32'(bus.num_outstanding), 32'd6);
        cyc(); bus.ld_miss = 16'h0001; bus.mem2proc_response = 4'd8; settle();
        chk("fill_0", 32'(bus.ld_gnt), 32'h0001);
        cyc(); bus.mem2proc_response = 4'd9; settle();
        chk("full_nout", 32'(bus.num_outstanding), 32'd8);
        chk("full_cmd",  32'(bus.proc2mem_command), 32'd0);
        chk("full_gnt",  32'(bus.ld_gnt), 32'd0);
        cyc(); bus.st_wr_en = 1'b1; bus.st_wr_addr = 16'h0200; bus.st_wr_data = 32'h55AA55AA;
        bus.st_wr_size = WORD; bus.mem2proc_response = 4'd10; settle();
        chk("full_st_cmd", 32'(bus.proc2mem_command), 32'd2);
        chk("full_st_rdy", 32'(bus.st_wr_ready), 32'd1);
        chk("full_st_gnt", 32'(bus.ld_gnt), 32'd0);
        cyc(); bus.st_wr_en = 1'b0; bus.mem2proc_response = 4'd9;
        bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 32'hA5A50003; settle();
        chk("full_ret_cmd", 32'(bus.proc2mem_command), 32'd0);
        chk("full_ret_gnt", 32'(bus.ld_gnt), 32'd0);
        cyc(); bus.mem2proc_tag = '0; bus.mem2proc_response = 4'd3; settle();
        chk("unfull_cmd", 32'(bus.proc2mem_command), 32'd1);
        chk("unfull_gnt", 32'(bus.ld_gnt), 32'h0001);
        chk("unfull_fb",  32'(bus.mem_feedback), 32'h0001);
        chk("unfull_dat", bus.mem_data, 32'hA5A50003);

        // flush: feedback registered the cycle before is suppressed
        cyc(); bus.ld_miss = '0; bus.mem2proc_response = '0;
        bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 32'h00000044; settle();
        chk("exc_nout8", 32'(bus.num_outstanding), 32'd8);
        cyc(); bus.mem2proc_tag = '0; bus.except = 1'b1; bus.ld_miss = 16'h0004;
        bus.ld_miss_addr[2] = 16'h0206; bus.mem2proc_response = 4'd11; settle();
        chk("exc_fb",  32'(bus.mem_feedback), 32'd0);
        chk("exc_cmd", 32'(bus.proc2mem_command), 32'd0);
        chk("exc_gnt", 32'(bus.ld_gnt), 32'd0);
        cyc(); bus.except = 1'b0; bus.ld_miss = '0; bus.mem2proc_response = '0;
        bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 32'h00001234; settle();
        chk("exc_nout0", 32'(bus.num_outstanding), 32'd0);
        cyc(); bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 32'h00005678; settle();
        chk("exc_drop1", 32'(bus.mem_feedback), 32'd0);
        cyc(); bus.mem2proc_tag = '0; settle();
        chk("exc_drop2", 32'(bus.mem_feedback), 32'd0);

        // backpressure on entry 2
        cyc(); bus.ld_miss = 16'h0004; bus.mem2proc_response = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_cmd",  32'(bus.proc2mem_command), 32'd1);
            chk("bp_addr", 32'(bus.proc2mem_addr), 32'h0204);
            chk("bp_gnt",  32'(bus.ld_gnt), 32'd0);
            cyc();
        end
        bus.mem2proc_response = 4'd4; settle();
        chk("bp_gnt_ok", 32'(bus.ld_gnt), 32'h0004);
        cyc(); bus.ld_miss = '0; bus.mem2proc_response = '0; settle();
        chk("bp_nout", 32'(bus.num_outstanding), 32'd1);

        // reset forgets outstanding tags
        cyc(); reset = 1'b1; settle();
        cyc(); reset = 1'b0; bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 32'h00004444; settle();
        chk("rst2_nout", 32'(bus.num_outstanding), 32'd0);
        cyc(); bus.mem2proc_tag = '0; settle();
        chk("rst2_fb", 32'(bus.mem_feedback), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
